inst_cache_resp: RTL and testbench
==================================

INST_CACHE_RESP -- requirements
Module: inst_cache_resp

Interface
REQ-001 Parameter INDEX_BITS, default 6, sets the line count to 2^INDEX_BITS direct-mapped lines of 4 words (16 B) each.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 cache_call_begin  in  1  one-cycle fetch request pulse from the PC stage.
REQ-005 cache_pc  in  32  virtual fetch address, valid in the cycle cache_call_begin=1.
REQ-006 cache_return_ready  out  1  one-cycle pulse; cache_inst is valid in that cycle.
REQ-007 cache_inst  out  32  returned instruction word.
REQ-008 inst_req  out  1  bus read request; held high until accepted.
REQ-009 inst_addr  out  32  bus physical word address, stable while inst_req=1.
REQ-010 inst_addr_ok  in  1  bus accepted the request this cycle.
REQ-011 inst_data_ok  in  1  read data valid this cycle.
REQ-012 inst_rdata  in  32  bus read data.

Function
REQ-013 Address translation is as follows:
- Addresses 0x8000_0000-0xBFFF_FFFF map to physical {3'b000, va[28:0]}.
- All other addresses pass through unchanged.
- va[1:0] is ignored; all addresses are forced word-aligned.
REQ-014 Addresses 0xA000_0000-0xBFFF_FFFF (kseg1) are uncached; all others are cacheable.
REQ-015 Physical address fields are: offset pa[3:2], index pa[INDEX_BITS+3:4], tag pa[31:INDEX_BITS+4].
REQ-016 The FSM states are IDLE, LOOKUP, MISS_REQ, MISS_WAIT, UNC_REQ, UNC_WAIT and RETURN.
REQ-017 IDLE: when cache_call_begin=1, latch the translated address and go to LOOKUP; any other input has no effect.
REQ-018 LOOKUP, hit (cacheable, valid, tag equal): select the word at the latched offset and go to RETURN.
REQ-019 LOOKUP, cacheable miss: set the word counter to 0 and go to MISS_REQ.
REQ-020 LOOKUP, uncached address: go to UNC_REQ without accessing the arrays.
REQ-021 MISS_REQ: drive inst_req=1 and inst_addr={tag,index,counter,2'b00}; on inst_addr_ok go to MISS_WAIT.
REQ-022 MISS_WAIT: on inst_data_ok, write inst_rdata into word[counter] of the line.
- If counter=3: set valid, write tag, go to RETURN.
- Otherwise: increment the counter and go to MISS_REQ.
REQ-023 Exactly one bus transaction is outstanding at any time; refill order is always word 0..3 (no critical-word-first).
REQ-024 The requested word's data is forwarded from the refilled line; a separate bypass register is permitted.
REQ-025 UNC_REQ: drive inst_req=1 and inst_addr=latched physical address; on inst_addr_ok go to UNC_WAIT.
REQ-026 UNC_WAIT: on inst_data_ok, capture inst_rdata and go to RETURN; no array write occurs.
REQ-027 RETURN: assert cache_return_ready=1 for exactly one cycle with cache_inst valid, then return to IDLE.
REQ-028 cache_inst holds its last returned value until the next RETURN.
REQ-029 Latencies, counted from the cache_call_begin sample edge:
- Hit: cache_return_ready is high in cycle +2.
- Miss with zero bus wait: +2+2*4.
REQ-030 cache_call_begin in any state other than IDLE is ignored; no request is queued.
REQ-031 inst_data_ok or inst_addr_ok outside their waiting states is ignored.
REQ-032 A refill to a valid line overwrites it; its valid bit is cleared when the refill starts and set only on completion.
REQ-033 inst_req is low in IDLE, LOOKUP, MISS_WAIT, UNC_WAIT and RETURN.

Reset
REQ-034 While resetn=0, the block shall hold: state=IDLE, all valid bits=0, counter=0, inst_req=0, inst_addr=0, cache_return_ready=0, cache_inst=0.
REQ-035 Reset asserted mid-refill or mid-uncached access shall abort the access; the line stays invalid, and a late inst_data_ok after release is ignored.
REQ-036 Tag and data arrays need no reset.

Verification
REQ-037 Uncached boot: after reset, call_begin with pc=0xBFC0_0000 -> one request with inst_addr=0x1FC0_0000; rdata=0x3C08BFC0 -> return_ready pulse, cache_inst=0x3C08BFC0; a repeat fetch issues a new bus request.
REQ-038 Cacheable miss then hit: pc=0x8000_0008 -> 4 requests at 0x0000_0000/4/8/C with data A0..A3 -> returns A2; then pc=0x8000_000C -> no bus request, cache_inst=A3 in cycle +2.
REQ-039 Conflict eviction: fill pc=0x8000_0000, then fetch pc=0x8000_0400 (same index, INDEX_BITS=6) -> refill at 0x400; then pc=0x8000_0000 -> miss again.
REQ-040 Bus stalls: inst_addr_ok delayed 3 cycles per request -> inst_req and inst_addr stay stable throughout; the correct word is returned; call_begin pulses during the refill have no effect.
REQ-041 Reset mid-refill: drop resetn after 2 refill words -> after release, state IDLE, a stray data_ok is ignored, and a fetch of the same pc misses and refills all 4 words.

Source files
------------

// File: rtl/inst_cache_resp.sv
// rtl/inst_cache_resp.sv - direct-mapped instruction cache with blocking refill and uncached path
module inst_cache_resp #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cache_call_begin,
  input  logic [31:0] cache_pc,
  output logic        cache_return_ready,
  output logic [31:0] cache_inst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_WAIT, S_UNC_REQ, S_UNC_WAIT, S_RETURN
  } state_e;

  state_e                state_q, state_d;
  logic [31:2]           pa_q;
  logic                  unc_q;
  logic [1:0]            cnt_q;
  logic [31:0]           fill_q;
  logic [31:0]           inst_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES*4];

  logic [31:2]           va_pa;
  logic                  va_unc;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [1:0]            off;
  logic                  hit;
  logic                  last_word;
  logic                  unused_pc_bits;

  // kseg0/kseg1 strip the top three bits; the low two address bits never matter
  assign va_pa          = (cache_pc[31:30] == 2'b10) ? {3'b000, cache_pc[28:2]} : cache_pc[31:2];
  assign va_unc         = (cache_pc[31:29] == 3'b101);
  assign unused_pc_bits = ^cache_pc[1:0];

  assign idx       = pa_q[INDEX_BITS+3:4];
  assign tag       = pa_q[31:INDEX_BITS+4];
  assign off       = pa_q[3:2];
  assign hit       = !unc_q && valid_q[idx] && (tag_mem[idx] == tag);
  assign last_word = (cnt_q == 2'd3);
  assign cache_inst = inst_q;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; one bus transaction at a time, refill always word 0..3
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (cache_call_begin) state_d = S_LOOKUP;
      S_LOOKUP:    if (unc_q)            state_d = S_UNC_REQ;
                   else if (hit)         state_d = S_RETURN;
                   else                  state_d = S_MISS_REQ;
      S_MISS_REQ:  if (inst_addr_ok)     state_d = S_MISS_WAIT;
      S_MISS_WAIT: if (inst_data_ok)     state_d = last_word ? S_RETURN : S_MISS_REQ;
      S_UNC_REQ:   if (inst_addr_ok)     state_d = S_UNC_WAIT;
      S_UNC_WAIT:  if (inst_data_ok)     state_d = S_RETURN;
      S_RETURN:                          state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // Bus request and return strobe decoded from state
  always_comb begin
    inst_req           = 1'b0;
    inst_addr          = 32'd0;
    cache_return_ready = 1'b0;
    case (state_q)
      S_MISS_REQ: begin
        inst_req  = 1'b1;
        inst_addr = {tag, idx, cnt_q, 2'b00};
      end
      S_UNC_REQ: begin
        inst_req  = 1'b1;
        inst_addr = {pa_q, 2'b00};
      end
      S_RETURN:  cache_return_ready = 1'b1;
      default:   ;
    endcase
  end

  // Request latch, refill counter, valid bits and returned-word register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pa_q    <= '0;
      unc_q   <= 1'b0;
      cnt_q   <= 2'd0;
      fill_q  <= 32'd0;
      inst_q  <= 32'd0;
      valid_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (cache_call_begin) begin
          pa_q  <= va_pa;
          unc_q <= va_unc;
        end
        S_LOOKUP: begin
          if (hit) begin
            inst_q <= data_mem[{idx, off}];
          end else if (!unc_q) begin
            cnt_q        <= 2'd0;
            valid_q[idx] <= 1'b0;
          end
        end
        S_MISS_WAIT: if (inst_data_ok) begin
          if (cnt_q == off) fill_q <= inst_rdata;
          if (last_word) begin
            valid_q[idx] <= 1'b1;
            inst_q       <= (off == 2'd3) ? inst_rdata : fill_q;
            cnt_q        <= 2'd0;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        S_UNC_WAIT: if (inst_data_ok) inst_q <= inst_rdata;
        default: ;
      endcase
    end
  end

  // Tag and data arrays; written only by the cacheable refill path
  always_ff @(posedge clk) begin
    if (state_q == S_MISS_WAIT && inst_data_ok) begin
      data_mem[{idx, cnt_q}] <= inst_rdata;
      if (last_word) tag_mem[idx] <= tag;
    end
  end

endmodule

// File: tb/tb_inst_cache_resp.sv
// tb/tb_inst_cache_resp.sv - scoreboard bench for inst_cache_resp
module tb_inst_cache_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cache_call_begin;
  logic [31:0] cache_pc;
  logic        cache_return_ready;
  logic [31:0] cache_inst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  inst_cache_resp #(.INDEX_BITS(6)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .cache_call_begin   (cache_call_begin),
    .cache_pc           (cache_pc),
    .cache_return_ready (cache_return_ready),
    .cache_inst         (cache_inst),
    .inst_req           (inst_req),
    .inst_addr          (inst_addr),
    .inst_addr_ok       (inst_addr_ok),
    .inst_data_ok       (inst_data_ok),
    .inst_rdata         (inst_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] addr_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acc_count = 0;
  int          dat_count = 0;
  int          ret_count = 0;
  int          stall     = 0;
  logic        stray_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1FC0_0000) return 32'h3C08_BFC0;
    return a ^ 32'hA5C3_0F0F;
  endfunction

  // Bus slave: optional addr_ok stall, data one cycle after acceptance
  initial begin
    logic        pend;
    logic        stray_ack;
    logic [31:0] pend_addr;
    logic [31:0] held;
    int          wc;
    pend = 1'b0; stray_ack = 1'b0; pend_addr = '0; held = '0; wc = 0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
    forever begin
      @(negedge clk);
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      if (!resetn) begin
        pend = 1'b0;
        wc   = 0;
      end else if (stray_req != stray_ack) begin
        stray_ack    = stray_req;
        inst_addr_ok = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEAD_BEEF;
      end else if (pend) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_word(pend_addr);
        pend         = 1'b0;
        dat_count++;
      end else if (inst_req) begin
        if (wc == 0) held = inst_addr;
        else check_eq("addr_stable", inst_addr, held);
        if (wc < stall) begin
          wc++;
        end else begin
          inst_addr_ok = 1'b1;
          pend         = 1'b1;
          pend_addr    = inst_addr;
          acc_count++;
          addr_log.push_back(inst_addr);
          wc = 0;
        end
      end
    end
  end

  // Return monitor: pops the scoreboard on every return strobe
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && cache_return_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_return", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq({e.name, "_inst"}, cache_inst, e.inst);
          check_eq({e.name, "_lat"}, cyc - e.t0, e.lat);
        end
        ret_count++;
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input int lat, input int exp_bus, input string name);
    int   a0, r0;
    exp_t e;
    logic [31:0] pa;
    pa = (pc[31:30] == 2'b10) ? {3'b000, pc[28:2], 2'b00} : {pc[31:2], 2'b00};
    a0 = acc_count;
    r0 = ret_count;
    addr_log.delete();
    @(negedge clk);
    cache_call_begin = 1'b1;
    cache_pc         = pc;
    e.inst = mem_word(pa); e.lat = lat; e.t0 = cyc; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    cache_call_begin = 1'b0;
    cache_pc         = 32'h0;
    for (int i = 0; i < 200 && ret_count == r0; i++) @(negedge clk);
    if (ret_count == r0) begin
      check_eq({name, "_timeout"}, 32'd0, 32'd1);
      sb.delete();
    end
    check_eq({name, "_bus"}, acc_count - a0, exp_bus);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int d0, r0;
    resetn = 1'b0;
    cache_call_begin = 1'b0;
    cache_pc = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", cache_return_ready, 0);
    check_eq("rst_req",   inst_req, 0);
    check_eq("rst_addr",  inst_addr, 0);
    check_eq("rst_inst",  cache_inst, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // uncached boot, and a repeat goes to the bus again
    fetch(32'hBFC0_0000, 4, 1, "boot");
    check_eq("boot_addr", addr_log[0], 32'h1FC0_0000);
    fetch(32'hBFC0_0000, 4, 1, "boot2");

    // cacheable miss then hits on the same line
    fetch(32'h8000_0008, 10, 4, "miss8");
    for (int i = 0; i < 4; i++) check_eq("refill_order", addr_log[i], 32'(i * 4));
    fetch(32'h8000_000C, 2, 0, "hitC");
    repeat (3) @(negedge clk);
    check_eq("inst_hold", cache_inst, mem_word(32'h0000_000C));
    fetch(32'h8000_000F, 2, 0, "hit_unaligned");
    fetch(32'h8000_0000, 2, 0, "hit0");

    // conflict eviction on index 0
    fetch(32'h8000_0400, 10, 4, "evict400");
    check_eq("evict_addr", addr_log[0], 32'h0000_0400);
    fetch(32'h8000_0000, 10, 4, "remiss0");

    // kseg1 never fills the array
    fetch(32'hA000_0010, 4, 1, "unc10");
    check_eq("unc_addr", addr_log[0], 32'h0000_0010);
    fetch(32'h8000_0010, 10, 4, "miss10");

    // kuseg passes straight through
    fetch(32'h0000_2238, 10, 4, "kuseg_miss");
    check_eq("kuseg_addr", addr_log[0], 32'h0000_2230);
    fetch(32'h0000_2238, 2, 0, "kuseg_hit");

    // stalled bus with call_begin pulses that must be ignored
    stall = 3;
    fork
      fetch(32'h8000_1234, 22, 4, "stall");
      begin
        repeat (4) @(negedge clk);
        repeat (3) begin
          cache_call_begin = 1'b1;
          cache_pc = 32'h8000_0008;
          @(negedge clk);
          cache_call_begin = 1'b0;
          repeat (2) @(negedge clk);
        end
      end
    join
    stall = 0;
    fetch(32'h8000_1238, 2, 0, "stall_line_hit");

    // reset in the middle of a refill
    d0 = dat_count;
    r0 = ret_count;
    @(negedge clk);
    cache_call_begin = 1'b1;
    cache_pc = 32'h8000_2000;
    @(negedge clk);
    cache_call_begin = 1'b0;
    for (int i = 0; i < 100 && dat_count < d0 + 2; i++) @(negedge clk);
    check_eq("abort_progress", dat_count - d0, 2);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_req",  inst_req, 0);
    check_eq("abort_inst", cache_inst, 0);
    resetn = 1'b1;
    @(negedge clk);
    stray_req = ~stray_req;
    repeat (5) @(negedge clk);
    check_eq("stray_no_return", ret_count - r0, 0);
    check_eq("stray_no_req", inst_req, 0);
    fetch(32'h8000_2000, 10, 4, "after_abort");
    check_eq("after_abort_addr", addr_log[0], 32'h0000_2000);
    fetch(32'h8000_0008, 10, 4, "post_reset_miss");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
